// File: rtl/mem_arbiter.sv
// Shared main-memory sequencer for I-cache fills, D-cache fills and write-through stores.
// One requester at a time; block fills issue WORDS consecutive reads and tag returns by offset.
module mem_arbiter #(
    parameter int WORDS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_miss,
    input  logic [15:0] i_miss_addr,
    input  logic        d_miss,
    input  logic [15:0] d_miss_addr,
    input  logic        st_req,
    input  logic [15:0] st_addr,
    input  logic [15:0] st_data,
    input  logic [15:0] mem_data_out,
    input  logic        mem_data_valid,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_in,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic [15:0] fill_data,
    output logic [2:0]  fill_offset,
    output logic        i_fill_valid,
    output logic        d_fill_valid,
    output logic        i_fill_done,
    output logic        d_fill_done,
    output logic        st_ack,
    output logic        stall
);
    localparam logic [2:0]  LAST     = 3'(WORDS - 1);
    localparam logic [15:0] BLK_MASK = ~16'(2 * WORDS - 1);

    typedef enum logic [1:0] {IDLE, STORE, DFILL, IFILL} state_t;

    state_t      state, next_state;
    logic [15:0] base;
    logic [2:0]  issue_cnt;
    logic        issue_done;
    logic [2:0]  ret_cnt;
    logic        in_fill;

    assign in_fill     = (state == DFILL) || (state == IFILL);
    assign fill_data   = mem_data_out;
    assign fill_offset = ret_cnt;
    assign stall       = st_req || d_miss || i_miss || (state != IDLE);

    // NOTE: every state element uses non-blocking assignment so all registers
    // update from the same pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            base       <= '0;
            issue_cnt  <= '0;
            issue_done <= 1'b0;
            ret_cnt    <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE) begin
                issue_cnt  <= '0;
                issue_done <= 1'b0;
                ret_cnt    <= '0;
                // Only meaningful when the grant goes to a fill; store ignores base.
                base <= d_miss ? (d_miss_addr & BLK_MASK) : (i_miss_addr & BLK_MASK);
            end else if (in_fill) begin
                if (!issue_done) begin
                    issue_cnt <= issue_cnt + 3'd1;
                    if (issue_cnt == LAST) issue_done <= 1'b1;
                end
                if (mem_data_valid) ret_cnt <= ret_cnt + 3'd1;
            end
        end
    end

    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state   = state;
        mem_addr     = '0;
        mem_data_in  = '0;
        mem_enable   = 1'b0;
        mem_wr       = 1'b0;
        st_ack       = 1'b0;
        i_fill_valid = 1'b0;
        d_fill_valid = 1'b0;
        i_fill_done  = 1'b0;
        d_fill_done  = 1'b0;

        case (state)
            IDLE: begin
                if (st_req)      next_state = STORE;
                else if (d_miss) next_state = DFILL;
                else if (i_miss) next_state = IFILL;
            end
            STORE: begin
                mem_enable  = 1'b1;
                mem_wr      = 1'b1;
                mem_addr    = st_addr;
                mem_data_in = st_data;
                st_ack      = 1'b1;
                next_state  = IDLE;
            end
            DFILL, IFILL: begin
                if (!issue_done) begin
                    mem_enable = 1'b1;
                    mem_addr   = base | {12'd0, issue_cnt, 1'b0};
                end
                if (mem_data_valid) begin
                    i_fill_valid = (state == IFILL);
                    d_fill_valid = (state == DFILL);
                    if (ret_cnt == LAST) begin
                        i_fill_done = (state == IFILL);
                        d_fill_done = (state == DFILL);
                        next_state  = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected memory reads and returned events are queued
// at stimulus time and popped by a negedge monitor as the DUT presents them.
module tb_mem_arbiter;
    localparam int LAT = 4;
    localparam logic [1:0] K_I = 2'd0, K_D = 2'd1, K_ST = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] a;
        logic [15:0] d;
        logic        done;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_miss = 1'b0, d_miss = 1'b0, st_req = 1'b0;
    logic [15:0] i_miss_addr = '0, d_miss_addr = '0, st_addr = '0, st_data = '0;
    logic [15:0] mem_data_out;
    logic        mem_data_valid;
    logic [15:0] mem_addr, mem_data_in, fill_data;
    logic        mem_enable, mem_wr, i_fill_valid, d_fill_valid;
    logic        i_fill_done, d_fill_done, st_ack, stall;
    logic [2:0]  fill_offset;

    logic           spur = 1'b0;
    logic [LAT-1:0] pv = '0;
    logic [15:0]    pa [LAT];

    int checks = 0;
    int failures = 0;
    ev_t         evq[$];
    logic [15:0] rq[$];

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_miss(i_miss), .i_miss_addr(i_miss_addr),
        .d_miss(d_miss), .d_miss_addr(d_miss_addr),
        .st_req(st_req), .st_addr(st_addr), .st_data(st_data),
        .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_enable(mem_enable), .mem_wr(mem_wr),
        .fill_data(fill_data), .fill_offset(fill_offset),
        .i_fill_valid(i_fill_valid), .d_fill_valid(d_fill_valid),
        .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
        .st_ack(st_ack), .stall(stall)
    );

    always #5 clk = ~clk;

    // Memory model: read issued in cycle c returns in cycle c+LAT; data derived from address.
    always @(posedge clk) begin
        pv[0] <= mem_enable && !mem_wr;
        pa[0] <= mem_addr;
        for (int i = 1; i < LAT; i++) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
        end
    end
    assign mem_data_valid = pv[LAT-1] || spur;
    assign mem_data_out   = spur ? 16'hDEAD : (pa[LAT-1] ^ 16'hA5C3);

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fill_exp(input logic [1:0] kind, input logic [15:0] addr, input int nr, input int nw);
        logic [15:0] b;
        b = addr & 16'hFFF0;
        for (int k = 0; k < nr; k++) rq.push_back(b | 16'(k << 1));
        for (int k = 0; k < nw; k++)
            evq.push_back('{kind, 16'(k), (b | 16'(k << 1)) ^ 16'hA5C3, k == 7});
    endtask

    task automatic store_exp(input logic [15:0] a, input logic [15:0] d);
        evq.push_back('{K_ST, a, d, 1'b1});
    endtask

    // Monitor: compare every presented event against the scoreboard head.
    always @(negedge clk) begin
        ev_t act, exp;
        logic [15:0] ra;
        if (i_fill_valid && d_fill_valid) check("valid_overlap", 48'd1, 48'd0);
        if ((i_fill_done && !i_fill_valid) || (d_fill_done && !d_fill_valid))
            check("done_without_valid", 48'd1, 48'd0);
        if (i_fill_valid || d_fill_valid || st_ack || (mem_enable && mem_wr)) begin
            if (mem_enable && mem_wr) act = '{K_ST, mem_addr, mem_data_in, st_ack};
            else if (d_fill_valid)    act = '{K_D, {13'd0, fill_offset}, fill_data, d_fill_done};
            else                      act = '{K_I, {13'd0, fill_offset}, fill_data, i_fill_done};
            if (evq.size() == 0) check("unexpected_event", 48'(act), 48'd0);
            else begin
                exp = evq.pop_front();
                check("event", 48'(act), 48'(exp));
            end
        end
        if (mem_enable && !mem_wr) begin
            if (rq.size() == 0) check("unexpected_read", 48'(mem_addr), 48'd0);
            else begin
                ra = rq.pop_front();
                check("read_addr", 48'(mem_addr), 48'(ra));
            end
        end
    end

    task automatic do_i(input logic [15:0] a);
        bit seen = 0;
        i_miss = 1'b1;
        i_miss_addr = a;
        @(negedge clk);
        check("stall_i_pending", 48'(stall), 48'd1);
        for (int n = 0; n < 100 && !seen; n++) begin
            if (i_fill_done) seen = 1;
            else @(negedge clk);
        end
        check("i_done_seen", 48'(seen), 48'd1);
        i_miss = 1'b0;
    endtask

    task automatic do_d(input logic [15:0] a);
        bit seen = 0;
        d_miss = 1'b1;
        d_miss_addr = a;
        @(negedge clk);
        check("stall_d_pending", 48'(stall), 48'd1);
        for (int n = 0; n < 100 && !seen; n++) begin
            if (d_fill_done) seen = 1;
            else @(negedge clk);
        end
        check("d_done_seen", 48'(seen), 48'd1);
        d_miss = 1'b0;
    endtask

    task automatic do_st(input logic [15:0] a, input logic [15:0] d);
        bit seen = 0;
        st_req = 1'b1;
        st_addr = a;
        st_data = d;
        @(negedge clk);
        check("stall_st_pending", 48'(stall), 48'd1);
        for (int n = 0; n < 100 && !seen; n++) begin
            if (st_ack) seen = 1;
            else @(negedge clk);
        end
        check("st_ack_seen", 48'(seen), 48'd1);
        st_req = 1'b0;
    endtask

    task automatic check_idle(input string name);
        check(name, {mem_enable, mem_wr, mem_addr, i_fill_valid, d_fill_valid,
                     i_fill_done, d_fill_done, st_ack, stall}, 48'd0);
    endtask

    initial begin
        bit hit;
        repeat (3) @(negedge clk);
        check_idle("reset_outputs");
        rst = 1'b0;
        @(negedge clk);
        check_idle("idle_after_reset");

        // Spurious return in IDLE must be ignored.
        spur = 1'b1;
        @(negedge clk);
        check("spurious_no_valid", {i_fill_valid, d_fill_valid}, 48'd0);
        spur = 1'b0;
        @(negedge clk);

        // Single I fill.
        fill_exp(K_I, 16'h1234, 8, 8);
        do_i(16'h1234);
        @(negedge clk);
        check_idle("idle_after_i_fill");

        // Simultaneous misses: D before I.
        fill_exp(K_D, 16'h8006, 8, 8);
        fill_exp(K_I, 16'h0040, 8, 8);
        fork
            do_d(16'h8006);
            do_i(16'h0040);
        join
        @(negedge clk);

        // Store arriving during an I fill waits for it.
        fill_exp(K_I, 16'h2226, 8, 8);
        store_exp(16'h0102, 16'hBEEF);
        fork
            do_i(16'h2226);
            begin
                repeat (3) @(negedge clk);
                do_st(16'h0102, 16'hBEEF);
            end
        join
        @(negedge clk);

        // Store and D miss together: store first.
        store_exp(16'h0204, 16'h1357);
        fill_exp(K_D, 16'h444A, 8, 8);
        fork
            do_st(16'h0204, 16'h1357);
            do_d(16'h444A);
        join
        @(negedge clk);

        // Reset on the third returned word: 7 reads issued, 3 words, no done.
        fill_exp(K_I, 16'h3008, 7, 3);
        i_miss = 1'b1;
        i_miss_addr = 16'h3008;
        hit = 0;
        for (int n = 0; n < 50 && !hit; n++) begin
            @(negedge clk);
            if (i_fill_valid && fill_offset == 3'd2) hit = 1;
        end
        check("third_word_seen", 48'(hit), 48'd1);
        rst = 1'b1;
        i_miss = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_idle("idle_after_mid_reset");
        repeat (10) @(negedge clk);
        fill_exp(K_I, 16'h3008, 8, 8);
        do_i(16'h3008);

        repeat (3) @(negedge clk);
        check("events_drained", 48'(evq.size()), 48'd0);
        check("reads_drained", 48'(rq.size()), 48'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
